// File: rtl/fpga_top.sv
// fpga_top: 8-bit accumulator processor running from an internal 16-entry ROM, driving the LEDs.
module fpga_top #(
    parameter logic [127:0] ROM_INIT = 128'h0000_0000_0000_0000_0000_0000_8121_7010,
    parameter int           STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_pin,
    output logic [7:0] led
);
    localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    logic [3:0]    pc;
    logic [7:0]    acc;
    logic [7:0]    acc_nx;
    logic          halt;
    logic [SW-1:0] cnt;
    logic          step;
    logic [7:0]    ins;
    logic [3:0]    op;
    logic [3:0]    imm;
    logic          jump;
    assign step = cnt == SW'(STEP_DIV - 1);
    assign ins  = ROM_INIT[{pc, 3'b000} +: 8];
    assign op   = ins[7:4];
    assign imm  = ins[3:0];
    // conditional jumps look at the accumulator as it stands before this edge
    assign jump = op == 4'h8 || (op == 4'h9 && acc != 8'h00) || (op == 4'hA && acc == 8'h00);
    always_comb begin
        acc_nx = acc;
        case (op)
            4'h1: acc_nx = {4'b0, imm};
            4'h2: acc_nx = acc + {4'b0, imm};
            4'h3: acc_nx = acc - {4'b0, imm};
            4'h4: acc_nx = acc ^ {4'b0, imm};
            4'h5: acc_nx = {acc[6:0], 1'b0};
            4'h6: acc_nx = {1'b0, acc[7:1]};
            default: acc_nx = acc;
        endcase
    end
    always_ff @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) begin
            pc   <= '0;
            acc  <= '0;
            led  <= '0;
            halt <= 1'b0;
            cnt  <= '0;
        end else begin
            cnt <= step ? '0 : cnt + 1'b1;
            if (step && !halt) begin
                acc  <= acc_nx;
                led  <= op == 4'h7 ? acc : led;
                halt <= op == 4'hB;
                pc   <= jump ? imm : op == 4'hB ? pc : pc + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_fpga_top.sv
// tb_fpga_top: directed checks of the default counter program, a custom ROM and a slowed step rate.
module tb_fpga_top;
    logic       clk = 1'b0;
    logic       rst_pin = 1'b0;
    logic [7:0] led_d;
    logic [7:0] led_c;
    logic [7:0] led_s;
    int         checks = 0;
    int         errors = 0;
    int         edges = 0;

    fpga_top u_def (.clk(clk), .rst_pin(rst_pin), .led(led_d));
    fpga_top #(.ROM_INIT(128'h0000_0000_0000_0000_B098_1070_5070_3615)) u_cus (.clk(clk), .rst_pin(rst_pin), .led(led_c));
    fpga_top #(.STEP_DIV(4)) u_div (.clk(clk), .rst_pin(rst_pin), .led(led_s));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, edges, got, exp);
        end
    endtask

    // advance to just after the given edge, sampling on the falling edge
    task automatic go(input int e);
        while (edges < e) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_def", led_d, 8'h00);
        check("reset_cus", led_c, 8'h00);
        check("reset_div", led_s, 8'h00);
        rst_pin = 1'b1;
        edges = 0;
        go(2);  check("cus_e2", led_c, 8'h00);
        go(3);  check("cus_ff", led_c, 8'hFF);
        go(4);  check("def_e4", led_d, 8'h00);
                check("cus_e4", led_c, 8'hFF);
        go(5);  check("def_e5", led_d, 8'h01);
                check("cus_fe", led_c, 8'hFE);
        go(8);  check("div_e8", led_s, 8'h00);
                check("cus_halt", led_c, 8'hFE);
        go(17); check("def_e17", led_d, 8'h05);
        go(18); check("def_e18", led_d, 8'h05);
        go(19); check("def_e19", led_d, 8'h05);
                check("div_e19", led_s, 8'h00);
        go(20); check("div_e20", led_s, 8'h01);
        go(31); check("div_e31", led_s, 8'h01);
        go(32); check("def_e32", led_d, 8'h0A);
                check("div_e32", led_s, 8'h02);
        go(120); check("cus_hold", led_c, 8'hFE);
        go(767); check("def_e767", led_d, 8'hFF);
        go(769); check("def_e769", led_d, 8'hFF);
        go(770); check("def_e770", led_d, 8'h00);
        go(773); check("def_e773", led_d, 8'h01);
        go(779); check("def_e779", led_d, 8'h03);
        #2 rst_pin = 1'b0;
        #1;
        check("midrst_def", led_d, 8'h00);
        check("midrst_cus", led_c, 8'h00);
        check("midrst_div", led_s, 8'h00);
        @(negedge clk);
        rst_pin = 1'b1;
        edges = 0;
        go(3);  check("re_cus_ff", led_c, 8'hFF);
        go(4);  check("re_def_e4", led_d, 8'h00);
        go(5);  check("re_def_e5", led_d, 8'h01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
